// File: rtl/riscv16_pkg.sv
// riscv16_pkg: shared types and constants for the 16-bit core
package riscv16_pkg;
    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_idx_t;
    localparam int NUM_REGS = 8;
    typedef struct packed {
        reg_idx_t tgt;
        word_t    data;
    } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: in-order FIFO of writeback entries with occupancy count
module wb_result_fifo
    import riscv16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    // storage needs no reset; contents are only visible through count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // wrap-around pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write port arbitration between load and ALU results, plus busy scoreboard
module wb_arbiter
    import riscv16_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    input  logic [2:0]                    issue_tgt,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [2:0]                    alu_tgt,
    input  logic [15:0]                   alu_data,
    input  logic                          mem_valid,
    input  logic [2:0]                    mem_tgt,
    input  logic [15:0]                   mem_data,
    output logic                          we_reg,
    output logic [2:0]                    tgt,
    output logic [15:0]                   write_data,
    output logic [7:0]                    busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    wb_entry_t             head, sel;
    logic                  full, empty, alu_acc, bypass, sel_valid, push, pop;
    logic [NUM_REGS-1:0]   busy_q, set_m, clr_m;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({alu_tgt, alu_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign alu_ready = !full;
    assign busy      = busy_q;

    // priority: load result, then oldest queued ALU result, then ALU bypass
    always_comb begin
        alu_acc   = alu_valid && !full;
        bypass    = alu_acc && !mem_valid && empty;
        push      = alu_acc && !bypass;
        pop       = !mem_valid && !empty;
        sel_valid = mem_valid || !empty || alu_acc;
        sel       = mem_valid ? {mem_tgt, mem_data} : !empty ? head : {alu_tgt, alu_data};
        set_m     = issue_valid ? NUM_REGS'(1) << issue_tgt : '0;
        clr_m     = we_reg ? NUM_REGS'(1) << tgt : '0;
    end

    // registered write port; index/data hold when nothing is selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg     <= 1'b0;
            tgt        <= '0;
            write_data <= '0;
        end else begin
            we_reg <= sel_valid && sel.tgt != '0;
            if (sel_valid) begin
                tgt        <= sel.tgt;
                write_data <= sel.data;
            end
        end
    end

    // scoreboard: issue sets, committed write clears, set wins, register 0 never busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else busy_q <= ((busy_q & ~clr_m) | set_m) & ~NUM_REGS'(1);
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, alu_valid, mem_valid;
    logic [2:0]  issue_tgt, alu_tgt, mem_tgt;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, we_reg;
    logic [2:0]  tgt;
    logic [15:0] write_data;
    logic [7:0]  busy;
    logic [2:0]  fifo_count;
    int          n_chk = 0;
    int          n_fail = 0;

    wb_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_tgt   (issue_tgt),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_tgt     (alu_tgt),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_tgt     (mem_tgt),
        .mem_data    (mem_data),
        .we_reg      (we_reg),
        .tgt         (tgt),
        .write_data  (write_data),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_tgt = '0;
        alu_valid = 1'b0; alu_tgt = '0; alu_data = '0;
        mem_valid = 1'b0; mem_tgt = '0; mem_data = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, we_reg, 0);
        chk({tag, "_tgt"}, tgt, 0);
        chk({tag, "_wd"}, write_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cnt"}, fifo_count, 0);
        chk({tag, "_rdy"}, alu_ready, 1);
    endtask

    initial begin
        int alu_d;
        logic rdy;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // bypass
        issue_valid = 1'b1; issue_tgt = 3'd3;
        tick();
        chk("byp_busy_set", busy, 8'h08);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_tgt = 3'd3; alu_data = 16'h1234;
        chk("byp_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("byp_we", we_reg, 1);
        chk("byp_tgt", tgt, 3);
        chk("byp_wd", write_data, 16'h1234);
        chk("byp_busy_n1", busy, 8'h08);
        chk("byp_cnt", fifo_count, 0);
        tick();
        chk("byp_busy_n2", busy, 8'h00);
        chk("byp_we_n2", we_reg, 0);
        chk("byp_hold_wd", write_data, 16'h1234);

        // collision
        mem_valid = 1'b1; mem_tgt = 3'd5; mem_data = 16'hBEEF;
        alu_valid = 1'b1; alu_tgt = 3'd2; alu_data = 16'h0042;
        tick();
        idle();
        chk("col_we1", we_reg, 1);
        chk("col_tgt1", tgt, 5);
        chk("col_wd1", write_data, 16'hBEEF);
        chk("col_cnt1", fifo_count, 1);
        tick();
        chk("col_we2", we_reg, 1);
        chk("col_tgt2", tgt, 2);
        chk("col_wd2", write_data, 16'h0042);
        chk("col_cnt2", fifo_count, 0);
        tick();
        chk("col_we3", we_reg, 0);

        // full FIFO under a 6-cycle memory burst
        alu_d = 1;
        for (int k = 0; k < 12; k++) begin
            mem_valid = k < 6; mem_tgt = 3'd7; mem_data = 16'hA000 + 16'(k);
            alu_valid = alu_d <= 6; alu_tgt = 3'd6; alu_data = 16'(alu_d);
            chk($sformatf("full_rdy_%0d", k), alu_ready, (k < 4 || k >= 7) ? 1 : 0);
            rdy = alu_ready;
            tick();
            if (alu_valid && rdy) alu_d++;
            if (k == 5) chk("full_accepted", alu_d - 1, 4);
            chk($sformatf("full_we_%0d", k), we_reg, 1);
            chk($sformatf("full_tgt_%0d", k), tgt, k < 6 ? 7 : 6);
            chk($sformatf("full_wd_%0d", k), write_data, k < 6 ? 32'hA000 + k : k - 5);
        end
        idle();
        chk("full_cnt_end", fifo_count, 0);
        tick();
        chk("full_we_end", we_reg, 0);

        // register 0
        alu_valid = 1'b1; alu_tgt = 3'd0; alu_data = 16'hFFFF;
        issue_valid = 1'b1; issue_tgt = 3'd0;
        tick();
        idle();
        chk("r0_we", we_reg, 0);
        chk("r0_busy", busy, 0);
        chk("r0_cnt", fifo_count, 0);
        tick();
        chk("r0_we2", we_reg, 0);

        // set/clear race on register 4
        issue_valid = 1'b1; issue_tgt = 3'd4;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_tgt = 3'd4; alu_data = 16'h4444;
        tick();
        alu_valid = 1'b0;
        chk("race_we", we_reg, 1);
        chk("race_tgt", tgt, 4);
        issue_valid = 1'b1; issue_tgt = 3'd4;
        tick();
        issue_valid = 1'b0;
        chk("race_busy", busy, 8'h10);
        tick();
        chk("race_busy2", busy, 8'h10);
        alu_valid = 1'b1; alu_tgt = 3'd4; alu_data = 16'h4445;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("race_clear", busy, 8'h00);

        // reset mid-operation
        for (int r = 2; r <= 5; r++) begin
            issue_valid = 1'b1; issue_tgt = 3'(r);
            tick();
        end
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_tgt = 3'd0; mem_data = 16'h0D0D;
            alu_valid = 1'b1; alu_tgt = 3'(i + 2); alu_data = 16'h0B02 + 16'(i);
            tick();
        end
        alu_valid = 1'b0;
        chk("rst_pre_cnt", fifo_count, 3);
        chk("rst_pre_busy", busy, 8'h3C);
        chk("rst_pre_wd", write_data, 16'h0D0D);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rst_after_we_%0d", i), we_reg, 0);
        end
        chk("rst_after_cnt", fifo_count, 0);
        chk("rst_after_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
